// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the iterative divider (slave).
interface ex_div_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// ex_div: radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// result_o = {remainder, quotient}. Optional macro DIV_EARLY_OUT_EN routes
// zero dividends and |divisor| > |dividend| through the short BYZERO path.
module ex_div #(
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_div_if.slave    div_if
);
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W-1:0]   a_abs_c;
  logic [DATA_W-1:0]   b_abs_c;
  logic                accept_c;
  logic                zero_div_c;
  logic                early_c;
  logic [DATA_W:0]     shift_c;
  logic [DATA_W:0]     trial_c;

  // Operand magnitudes, acceptance and shortcut detection in FREE
  always_comb begin
    a_abs_c = div_if.opdata1_i;
    b_abs_c = div_if.opdata2_i;
    if (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1]) a_abs_c = DATA_W'(-div_if.opdata1_i);
    if (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1]) b_abs_c = DATA_W'(-div_if.opdata2_i);
    accept_c   = div_if.start_i && !div_if.annul_i;
    zero_div_c = (div_if.opdata2_i == '0);
`ifdef DIV_EARLY_OUT_EN
    early_c    = (div_if.opdata1_i == '0) || (b_abs_c > a_abs_c);
`else
    early_c    = 1'b0;
`endif
  end

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  always_comb begin
    shift_c = {rem_q, quo_q[DATA_W-1]};
    trial_c = shift_c - {1'b0, dvs_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FREE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FREE: begin
        if (accept_c) begin
          if (zero_div_c || early_c) state_d = ST_BYZERO;
          else                       state_d = ST_ON;
        end
      end
      ST_BYZERO: state_d = ST_END;
      ST_ON: begin
        if (div_if.annul_i)                  state_d = ST_FREE;
        else if (cnt_q == CNT_W'(DATA_W))    state_d = ST_END;
      end
      ST_END: begin
        if (div_if.annul_i || !div_if.start_i) state_d = ST_FREE;
      end
      default: state_d = ST_FREE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;
    unique case (state_q)
      ST_FREE: begin
        if (accept_c) begin
          cnt_d     = '0;
          dvs_d     = b_abs_c;
          if (zero_div_c) begin
            rem_d     = '0;
            quo_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else if (early_c) begin
            // Quotient is zero, remainder is the untouched dividend
            rem_d     = div_if.opdata1_i;
            quo_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            rem_d     = '0;
            quo_d     = a_abs_c;
            neg_quo_d = div_if.signed_div_i &&
                        (div_if.opdata1_i[DATA_W-1] ^ div_if.opdata2_i[DATA_W-1]);
            neg_rem_d = div_if.signed_div_i && div_if.opdata1_i[DATA_W-1];
          end
        end
      end
      ST_ON: begin
        if (!div_if.annul_i) begin
          if (cnt_q < CNT_W'(DATA_W)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial_c[DATA_W]) begin
              rem_d = trial_c[DATA_W-1:0];
              quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
              rem_d = shift_c[DATA_W-1:0];
              quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            // Sign fix-up; the most-negative / -1 case wraps naturally
            if (neg_quo_q) quo_d = DATA_W'(-quo_q);
            if (neg_rem_q) rem_d = DATA_W'(-rem_q);
          end
        end
      end
      ST_END: begin
        if (div_if.start_i && !div_if.annul_i) begin
          ready_d  = 1'b1;
          result_d = {rem_q, quo_q};
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Bench for ex_div: directed spec cases plus randomized ops against an arithmetic model.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  ex_div_if #(.DATA_W(32)) dif ();

  ex_div #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain language arithmetic (truncating division, remainder takes dividend sign)
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint aa, bb;
    aa = s ? longint'($signed(a)) : longint'(a);
    bb = s ? longint'($signed(b)) : longint'(b);
    if (aa < 0) aa = -aa;
    if (bb < 0) bb = -bb;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (a == 32'd0 || bb > aa) return 2;
`endif
    return 34;
  endfunction

  // Issue one op, measure latency, check result, hold, and release
  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res);
    int lat;
    int want;
    want = exp_lat(s, a, b);
    @(negedge clk);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    dif.signed_div_i = 1'($urandom);      // must be ignored after E0
    dif.opdata1_i    = $urandom;
    dif.opdata2_i    = $urandom;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dif.ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(want));
    check({tag, "_result"}, dif.result_o, exp_res);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {dif.result_o[62:0], dif.ready_o}, {exp_res[62:0], 1'b1});
    end
    @(negedge clk);
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_release"}, {dif.result_o[62:0], dif.ready_o}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(dif.ready_o), 64'd0);
    check("reset_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14});
    run_op("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000});
    run_op("divu_5_0",     1'b0, 32'd5,          32'd0,          64'd0);
    run_op("divu_0_9",     1'b0, 32'd0,          32'd9,          64'd0);
    run_op("divu_3_9",     1'b0, 32'd3,          32'd9,          {32'd3, 32'd0});
    run_op("div_m3_9",     1'b1, 32'hFFFFFFFD,   32'd9,          {32'hFFFFFFFD, 32'd0});

    // Annul mid-flight at E0+10: ready must never rise
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    @(posedge clk);                       // E0
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk);                       // E0+10
    @(negedge clk);
    dif.annul_i = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (dif.ready_o !== 1'b0) seen++;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
    end
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // start and annul together in FREE: not accepted
    @(negedge clk);
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (dif.ready_o !== 1'b0) seen++;
      end
      check("start_annul_ignored", 64'(seen), 64'd0);
    end

    // Reset at E0+20 aborts the op
    @(negedge clk);
    dif.signed_div_i = 1'b1;
    dif.opdata1_i    = 32'd12345;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    @(posedge clk);                       // E0
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;                   // E0+20
    check("rst_mid_ready", 64'(dif.ready_o), 64'd0);
    check("rst_mid_result", dif.result_o, 64'd0);
    @(negedge clk);
    rst         = 1'b0;
    dif.start_i = 1'b0;
    run_op("after_rst", 1'b1, 32'hFFFFFF9C, 32'd7, ref_div(1'b1, 32'hFFFFFF9C, 32'd7));

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'd0;
        2:       b = a + 32'($urandom_range(1, 100));
        3:       begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
        default: b = $urandom;
      endcase
      if ((i % 7) == 3) a = 32'd0;
      run_op("rand", s, a, b, ref_div(s, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
